// File: rtl/ad7264_spi_responder.sv
// ad7264_spi_responder: SPI slave emulating one dual-channel AD7264.
// Ports: clk/reset, SPI pins SCLK/SS/MOSI, mode CPOL/CPHA, sampleA/B in;
// MISOA/MISOB/misoOE, cmdData/cmdValid, frameDone/frameError out.
module ad7264_spi_responder (
  input  logic        clk,
  input  logic        reset,
  input  logic        SCLK,
  input  logic        SS,
  input  logic        MOSI,
  input  logic        CPOL,
  input  logic        CPHA,
  input  logic [13:0] sampleA,
  input  logic [13:0] sampleB,
  output logic        MISOA,
  output logic        MISOB,
  output logic        misoOE,
  output logic [15:0] cmdData,
  output logic        cmdValid,
  output logic        frameDone,
  output logic        frameError
);

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA,
    DONE
  } state_t;

  state_t      state;
  logic [2:0]  sclkSync;
  logic [2:0]  ssSync;
  logic [1:0]  mosiSync;
  logic        cpolL;
  logic        cphaL;
  logic [13:0] sampA;
  logic [13:0] sampB;
  logic [5:0]  cnt;
  logic [15:0] cmdShift;

  logic        sclkRise;
  logic        sclkFall;
  logic        ssFall;
  logic        ssRise;
  logic        sampleEdge;
  logic        driveEdge;
  logic        edgeTaken;
  logic [5:0]  cntNext;
  logic [15:0] shiftNext;

  // Bit n of the 32-bit reply frame: 18 zeros, then the sample MSB first.
  // Counts of 32 and above (after the frame) always give 0.
  function automatic logic bitOf(input logic [13:0] s, input logic [5:0] n);
    logic [31:0] w;
    w = {18'd0, s};
    return n[5] ? 1'b0 : w[5'd31 - n[4:0]];
  endfunction

  // SS syncs reset low so that SS held low across reset never
  // looks like a fresh fall; a frame in progress is not resumed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclkSync <= '0;
      ssSync   <= '0;
      mosiSync <= '0;
    end else begin
      sclkSync <= {sclkSync[1:0], SCLK};
      ssSync   <= {ssSync[1:0], SS};
      mosiSync <= {mosiSync[0], MOSI};
    end
  end

  always_comb begin
    sclkRise   = sclkSync[1] & ~sclkSync[2];
    sclkFall   = ~sclkSync[1] & sclkSync[2];
    ssFall     = ~ssSync[1] & ssSync[2];
    ssRise     = ssSync[1] & ~ssSync[2];
    sampleEdge = (cpolL ^ cphaL) ? sclkFall : sclkRise;
    driveEdge  = (cpolL ^ cphaL) ? sclkRise : sclkFall;
    edgeTaken  = sampleEdge & ((state == CMD) | (state == DATA));
    cntNext    = edgeTaken ? cnt + 6'd1 : cnt;
    shiftNext  = cmdShift;
    if (edgeTaken && state == CMD) begin
      shiftNext = {cmdShift[14:0], mosiSync[1]};
    end
  end

  // The sample edge is folded into cntNext first, so an SS rise on the
  // same clk as edge 32 still reports a complete frame.
  // Both CPHA modes reduce to: a drive edge presents bit[cnt].
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      cmdShift   <= '0;
      cpolL      <= 1'b0;
      cphaL      <= 1'b0;
      sampA      <= '0;
      sampB      <= '0;
      MISOA      <= 1'b0;
      MISOB      <= 1'b0;
      misoOE     <= 1'b0;
      cmdData    <= '0;
      cmdValid   <= 1'b0;
      frameDone  <= 1'b0;
      frameError <= 1'b0;
    end else begin
      cmdValid   <= 1'b0;
      frameDone  <= 1'b0;
      frameError <= 1'b0;
      unique case (state)
        IDLE: begin
          if (ssFall) begin
            cpolL  <= CPOL;
            cphaL  <= CPHA;
            sampA  <= sampleA;
            sampB  <= sampleB;
            cnt    <= '0;
            misoOE <= 1'b1;
            MISOA  <= 1'b0;
            MISOB  <= 1'b0;
            state  <= CMD;
          end
        end
        CMD, DATA, DONE: begin
          cnt      <= cntNext;
          cmdShift <= shiftNext;
          if (edgeTaken && state == CMD && cntNext == 6'd16) begin
            cmdData  <= shiftNext;
            cmdValid <= 1'b1;
          end
          if (ssRise) begin
            frameDone  <= (cntNext == 6'd32);
            frameError <= (cntNext != 6'd32);
            misoOE     <= 1'b0;
            MISOA      <= 1'b0;
            MISOB      <= 1'b0;
            state      <= IDLE;
          end else begin
            if (state == CMD && cntNext == 6'd16) begin
              state <= DATA;
            end
            if (state == DATA && cntNext == 6'd32) begin
              state <= DONE;
            end
            if (state == DONE) begin
              MISOA <= 1'b0;
              MISOB <= 1'b0;
            end else if (driveEdge) begin
              MISOA <= bitOf(sampA, cnt);
              MISOB <= bitOf(sampB, cnt);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ad7264_spi_responder.md
# ad7264_spi_responder

SPI slave that emulates one dual-channel AD7264 on the far end of the ADC SPI bus, for bench and hardware-in-loop testing of the sonar acquisition path without real converters. It oversamples SCLK/SS/MOSI on a local system clock and captures the 16-bit command word the master shifts out. It then returns two 14-bit samples, one per channel, on MISO_A and MISO_B in the same 32-SCLK frame format the master's deserializers expect. It also reports frame completion and framing errors to local test logic.

## Interface
- No parameters; frame length fixed at 32 SCLK periods.
- clk  input  1  system clock; must be ≥ 8× SCLK frequency.
- reset  input  1  asynchronous, active-high; clears all state.
- SCLK  input  1  SPI clock from master (asynchronous to clk).
- SS  input  1  SPI slave select, active-low (asynchronous to clk).
- MOSI  input  1  command data from master, MSB first.
- CPOL  input  1  SPI clock polarity; latched at SS falling edge.
- CPHA  input  1  SPI clock phase; latched at SS falling edge.
- sampleA  input  14  channel A value to return; latched at SS falling edge.
- sampleB  input  14  channel B value to return; latched at SS falling edge.
- MISOA  output  1  channel A serial data.
- MISOB  output  1  channel B serial data.
- misoOE  output  1  tristate enable for MISOA/MISOB; 1 only while SS low.
- cmdData  output  16  last complete command word; held until the next one.
- cmdValid  output  1  one-clk pulse when cmdData updates.
- frameDone  output  1  one-clk pulse at SS rise after a full 32-bit frame.
- frameError  output  1  one-clk pulse at SS rise after fewer than 32 sample edges.

## Operation
- SCLK, SS and MOSI each pass through a 2-FF synchronizer. A third register stage detects edges.
- Sample edge: rising SCLK when CPOL^CPHA=0, falling otherwise. Drive edge: the opposite SCLK edge.
- The bit counter is 6 bits. It counts sample edges since SS fell, 0..32, and saturates at 32.
- States:
  - IDLE: waiting for SS to fall.
  - CMD: sample edges 0–15.
  - DATA: sample edges 16–31.
  - DONE: 32 edges seen, waiting for SS to rise.
- IDLE→CMD on SS fall. On that transition, latch CPOL, CPHA, sampleA and sampleB, clear the counter, and set misoOE=1.
- CMD: at each sample edge, shift synchronized MOSI into the command shift register (MSB first). At the 16th sample edge, copy the register to cmdData, pulse cmdValid, and go to DATA.
- DATA: at the 32nd sample edge, go to DONE.
- DONE: further SCLK edges are ignored and MISO drives 0.
- MISO bit n is the value the master samples at sample edge n:
  - bits 0–17 are 0 (16 command periods plus 2 leading zeros);
  - bits 18–31 are sample[13-(n-18)], MSB first.
- MISO updates on drive edges:
  - CPHA=0: bit 0 is presented at SS fall; bit n+1 is presented at the drive edge following sample edge n.
  - CPHA=1: bit n is presented at the drive edge preceding sample edge n.
- SS rise in any non-IDLE state:
  - counter=32: pulse frameDone;
  - counter<32: pulse frameError (the cmdValid rules for a short frame are in Timing);
  - in both cases: misoOE=0, MISO=0, go to IDLE.
- SS rise while already in IDLE: no pulse.
- SCLK activity while SS is high is ignored.

## Timing
- Reset values:
  - state IDLE, counter 0;
  - MISOA=MISOB=0, misoOE=0;
  - cmdData=0, cmdValid=frameDone=frameError=0.
- Pin-to-action latency: 3 clk cycles from an SCLK/SS pin edge to the registered response (+1 clk for asynchronous sampling uncertainty).
- This latency applies to MISO, misoOE, cmdValid, frameDone and frameError.
- cmdValid, frameDone and frameError are exactly one clk wide.
- frameDone and frameError are mutually exclusive.
- cmdValid never fires in a frame shorter than 16 sample edges. In that case cmdData keeps its previous value.
- SS rise on the same clk as a detected sample edge: the edge is processed first, then the SS rise.
  - Consequence: edge 32 arriving together with SS rise gives frameDone.
- Reset asserted mid-frame: all outputs return to reset values immediately (asynchronously).
  - After reset release, the block waits in IDLE for a fresh SS fall. A frame already in progress is not resumed.

## Test plan
- Mode 0 (CPOL=0, CPHA=0), SCLK = clk/8, MOSI word 0xA5C3, sampleA=0x2AAA, sampleB=0x1555, 32 SCLKs then SS rise:
  - cmdData=0xA5C3 with one cmdValid pulse;
  - master-side capture of bits 18–31 gives 0x2AAA on A and 0x1555 on B;
  - one frameDone pulse, no frameError.
- Repeat the above in modes 1, 2 and 3 with sampleA=0x3FFF, sampleB=0x0001: identical decoded results in every mode.
- SS rises after 10 SCLKs: frameError pulse; no cmdValid; cmdData unchanged; misoOE=0 within 4 clk.
- 40 SCLKs while SS low: extra edges ignored; MISO=0 after bit 31; one frameDone at SS rise.
- sampleA changes from 0x0100 to 0x3000 mid-frame: returned value is 0x0100 (latched at SS fall).
- Reset pulsed at SCLK 20: misoOE=0, MISO=0 and counter cleared at once. The next full frame returns correct data.
